usb_slave_ep_regfile: RTL and testbench
=======================================

// Module: usb_slave_ep_regfile
// PURPOSE
//  Host-side register bank for the 4 USB slave endpoints. Holds the per-endpoint control
//  registers read by the endpoint mux (endPnControlReg). Exposes the mux's status and trans-type
//  registers to the host bus. Auto-clears EP_READY when the mux pulses clrEPnRdy, and raises a
//  maskable interrupt on transaction-done and NAK events. Sits between the host bus and the mux.
// PARAMETERS
//  CTRL_RST      5'h00  reset value of every EPn control register
//  INT_MASK_RST  8'h00  reset value of INT_MASK
// PORTS
//  clk             in   1  clock
//  rst             in   1  reset, synchronous, active-high
//  bus_stb         in   1  bus access request; held until bus_ack
//  bus_we          in   1  1 = write, 0 = read; valid with bus_stb
//  bus_addr        in   5  register address
//  bus_wdata       in   8  write data
//  bus_rdata       out  8  read data; valid in the cycle bus_ack=1
//  bus_ack         out  1  one-cycle access-complete pulse
//  epN_ctrl        out  5  N=0..3; control reg to mux: [0]EN [1]READY [2]DATA_SEQ [3]SEND_STALL [4]ISO
//  epN_status      in   8  N=0..3; status reg from mux (bit4 = NAK sent)
//  epN_tt          in   2  N=0..3; transType reg from mux
//  epN_nak_tt      in   2  N=0..3; NAK transType reg from mux
//  clr_epN_rdy     in   1  N=0..3; ready-clear level from mux (registered, may stay high)
//  irq             out  1  interrupt, level
// BEHAVIOUR
//  Address map (unlisted or reserved addresses read 0; writes to them are ignored):
//   4n+0  EPn_CTRL rw[4:0], reads {3'b0,ctrl}
//   4n+1  EPn_STATUS ro
//   4n+2  EPn_TT ro {4'b0,nak_tt,tt}
//   4n+3  reserved
//   0x10  INT_STAT: bits[3:0] DONE per ep, [7:4] NAK per ep; write-1-to-clear
//   0x11  INT_MASK rw
//  Bus handshake:
//   - Idle/ack FSM, states IDLE -> ACK -> IDLE.
//   - In IDLE with bus_stb=1: the access is performed that cycle (write registered, read data
//     registered). bus_ack=1 and bus_rdata are presented the next cycle (ACK).
//   - ACK always returns to IDLE. A stb still high in ACK is not a new access.
//   - Back-to-back accesses therefore complete every 2 cycles.
//   - bus_rdata returns 0 outside ACK.
//  Event detection:
//   - clr_epN_rdy and epN_status[4] each pass through a 1-flop delay.
//   - An event is its rising edge (cur & ~prev).
//   - The delay flops reset to 0.
//  READY auto-clear:
//   - A clr_epN_rdy rising edge forces ctrl[N][1]=0 and sets INT_STAT[N].
//   - A held-high clr level must not clear READY again.
//   - Simultaneous host write to EPn_CTRL: the write applies to all other bits; READY=0 (hw wins).
//  NAK interrupt:
//   - An epN_status[4] rising edge sets INT_STAT[4+N].
//  INT_STAT update per bit: next = (cur & ~w1c) | set. Set wins over a simultaneous W1C.
//  irq: registered, irq <= |(INT_STAT & INT_MASK); one cycle latency from a stat/mask change.
//  Reset values:
//   - epN_ctrl=CTRL_RST, INT_MASK=INT_MASK_RST, INT_STAT=0.
//   - irq=0, bus_ack=0, bus_rdata=0, FSM=IDLE.
//   - Reset mid-access aborts it: no ack, and the write is not applied if rst is high in that cycle.
//  Read of INT_STAT returns the pre-update value (events in the same cycle are visible on next read).
// TESTING
//  1. Reset: all ctrl = CTRL_RST, irq=0. Read 0x11 -> 8'h00; read 0x13 -> 8'h00.
//  2. Write 0x08 <= 5'h03:
//     - ep2_ctrl=5'h03 one cycle after the access.
//     - bus_ack high exactly 1 cycle.
//     - Read 0x08 -> 8'h03.
//  3. EP1 ctrl=5'h03, INT_MASK=8'h02; raise clr_ep1_rdy and hold it 10 cycles:
//     - ep1_ctrl becomes 5'h01 once.
//     - INT_STAT=8'h02; irq=1 one cycle later.
//     - Re-write READY=1 while clr is still high -> READY stays 1.
//  4. Same cycle as a clr_ep0_rdy edge, host writes 0x00 <= 5'h1F -> ep0_ctrl=5'h1D.
//  5. ep3_status 8'h00 -> 8'h10 -> INT_STAT[7]=1. W1C 0x10 <= 8'h80 on the same cycle as a
//     new edge -> bit stays 1. Without an edge -> clears; irq drops 1 cycle later.
//  6. Assert rst during IDLE->ACK of a write to 0x04 -> no bus_ack, ep1_ctrl=CTRL_RST.

Source files
------------

// File: rtl/usb_slave_ep_regfile.sv
// Host register bank for the four USB slave endpoints: per-endpoint control
// registers driven to the endpoint mux, read-only views of the mux status and
// trans-type registers, READY auto-clear, and a maskable done/NAK interrupt.
module usb_slave_ep_regfile #(
  parameter logic [4:0] CTRL_RST     = 5'h00,
  parameter logic [7:0] INT_MASK_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_stb,
  input  logic       bus_we,
  input  logic [4:0] bus_addr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       bus_ack,
  output logic [4:0] ep0_ctrl,
  output logic [4:0] ep1_ctrl,
  output logic [4:0] ep2_ctrl,
  output logic [4:0] ep3_ctrl,
  input  logic [7:0] ep0_status,
  input  logic [7:0] ep1_status,
  input  logic [7:0] ep2_status,
  input  logic [7:0] ep3_status,
  input  logic [1:0] ep0_tt,
  input  logic [1:0] ep1_tt,
  input  logic [1:0] ep2_tt,
  input  logic [1:0] ep3_tt,
  input  logic [1:0] ep0_nak_tt,
  input  logic [1:0] ep1_nak_tt,
  input  logic [1:0] ep2_nak_tt,
  input  logic [1:0] ep3_nak_tt,
  input  logic       clr_ep0_rdy,
  input  logic       clr_ep1_rdy,
  input  logic       clr_ep2_rdy,
  input  logic       clr_ep3_rdy,
  output logic       irq
);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       access;
  logic       wr;

  logic [4:0] ctrl_q [4];
  logic [4:0] ctrl_d [4];
  logic [7:0] status [4];
  logic [3:0] tt     [4];

  logic [3:0] clr_in, clr_prev_q, clr_evt;
  logic [3:0] nak_in, nak_prev_q, nak_evt;

  logic [7:0] stat_q, stat_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] w1c;
  logic [7:0] rd_mux;
  logic [7:0] rdata_q, rdata_d;
  logic       irq_q;

  assign status[0] = ep0_status;
  assign status[1] = ep1_status;
  assign status[2] = ep2_status;
  assign status[3] = ep3_status;
  assign tt[0]     = {ep0_nak_tt, ep0_tt};
  assign tt[1]     = {ep1_nak_tt, ep1_tt};
  assign tt[2]     = {ep2_nak_tt, ep2_tt};
  assign tt[3]     = {ep3_nak_tt, ep3_tt};

  assign clr_in  = {clr_ep3_rdy, clr_ep2_rdy, clr_ep1_rdy, clr_ep0_rdy};
  assign nak_in  = {ep3_status[4], ep2_status[4], ep1_status[4], ep0_status[4]};
  // Only rising edges count, so a mux that holds clr high clears READY once.
  assign clr_evt = clr_in & ~clr_prev_q;
  assign nak_evt = nak_in & ~nak_prev_q;

  // Handshake FSM: an access is taken in IDLE and acknowledged in ACK.
  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      IDLE: if (bus_stb) begin
        access  = 1'b1;
        state_d = ACK;
      end
      ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr = access & bus_we;

  // Register next-state: host writes, hardware READY clear, sticky interrupt status.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      ctrl_d[n] = ctrl_q[n];
      if (wr && bus_addr == {1'b0, 2'(n), 2'b00}) ctrl_d[n] = bus_wdata[4:0];
      if (clr_evt[n]) ctrl_d[n][1] = 1'b0;
    end
    w1c    = (wr && bus_addr == 5'h10) ? bus_wdata : 8'h00;
    stat_d = (stat_q & ~w1c) | {nak_evt, clr_evt};
    mask_d = (wr && bus_addr == 5'h11) ? bus_wdata : mask_q;
  end

  // Read decode; INT_STAT is read before this cycle's events land.
  always_comb begin
    rd_mux = 8'h00;
    if (!bus_addr[4]) begin
      case (bus_addr[1:0])
        2'd0:    rd_mux = {3'b000, ctrl_q[bus_addr[3:2]]};
        2'd1:    rd_mux = status[bus_addr[3:2]];
        2'd2:    rd_mux = {4'b0000, tt[bus_addr[3:2]]};
        default: rd_mux = 8'h00;
      endcase
    end else if (bus_addr == 5'h10) begin
      rd_mux = stat_q;
    end else if (bus_addr == 5'h11) begin
      rd_mux = mask_q;
    end
    rdata_d = (access && !bus_we) ? rd_mux : 8'h00;
  end

  // State, registers, edge-detect history and irq; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int n = 0; n < 4; n++) ctrl_q[n] <= CTRL_RST;
      stat_q     <= 8'h00;
      mask_q     <= INT_MASK_RST;
      clr_prev_q <= 4'h0;
      nak_prev_q <= 4'h0;
      rdata_q    <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      for (int n = 0; n < 4; n++) ctrl_q[n] <= ctrl_d[n];
      stat_q     <= stat_d;
      mask_q     <= mask_d;
      clr_prev_q <= clr_in;
      nak_prev_q <= nak_in;
      rdata_q    <= rdata_d;
      irq_q      <= |(stat_q & mask_q);
    end
  end

  assign bus_ack   = (state_q == ACK);
  assign bus_rdata = rdata_q;
  assign irq       = irq_q;
  assign ep0_ctrl  = ctrl_q[0];
  assign ep1_ctrl  = ctrl_q[1];
  assign ep2_ctrl  = ctrl_q[2];
  assign ep3_ctrl  = ctrl_q[3];

endmodule

// File: tb/tb_usb_slave_ep_regfile.sv
// Directed bench for usb_slave_ep_regfile: bus accesses with a read-data
// scoreboard, READY auto-clear, NAK interrupt, W1C races and mid-access reset.
module tb_usb_slave_ep_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic       bus_stb, bus_we;
  logic [4:0] bus_addr;
  logic [7:0] bus_wdata, bus_rdata;
  logic       bus_ack;
  logic [4:0] ep0_ctrl, ep1_ctrl, ep2_ctrl, ep3_ctrl;
  logic [7:0] ep0_status, ep1_status, ep2_status, ep3_status;
  logic [1:0] ep0_tt, ep1_tt, ep2_tt, ep3_tt;
  logic [1:0] ep0_nak_tt, ep1_nak_tt, ep2_nak_tt, ep3_nak_tt;
  logic       clr_ep0_rdy, clr_ep1_rdy, clr_ep2_rdy, clr_ep3_rdy;
  logic       irq;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       irq_at_ack;

  usb_slave_ep_regfile #(.CTRL_RST(5'h00), .INT_MASK_RST(8'h00)) dut (
    .clk(clk), .rst(rst),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .ep0_ctrl(ep0_ctrl), .ep1_ctrl(ep1_ctrl), .ep2_ctrl(ep2_ctrl), .ep3_ctrl(ep3_ctrl),
    .ep0_status(ep0_status), .ep1_status(ep1_status),
    .ep2_status(ep2_status), .ep3_status(ep3_status),
    .ep0_tt(ep0_tt), .ep1_tt(ep1_tt), .ep2_tt(ep2_tt), .ep3_tt(ep3_tt),
    .ep0_nak_tt(ep0_nak_tt), .ep1_nak_tt(ep1_nak_tt),
    .ep2_nak_tt(ep2_nak_tt), .ep3_nak_tt(ep3_nak_tt),
    .clr_ep0_rdy(clr_ep0_rdy), .clr_ep1_rdy(clr_ep1_rdy),
    .clr_ep2_rdy(clr_ep2_rdy), .clr_ep3_rdy(clr_ep3_rdy),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Starts at a negedge, returns at the negedge after the ack cycle.
  task automatic access(input logic we, input logic [4:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp);
    int n;
    if (!we) exp_q.push_back(exp);
    bus_stb = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_ack && n < 4);
    chk("ack_seen", {7'b0, bus_ack}, 8'h01);
    irq_at_ack = irq;
    if (!we && exp_q.size() > 0) begin
      if (bus_ack) chk($sformatf("rdata_%h", addr), bus_rdata, exp_q.pop_front());
      else void'(exp_q.pop_front());
    end
    bus_stb = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", {7'b0, bus_ack}, 8'h00);
    chk("rdata_idle", bus_rdata, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus_stb = 1'b0; bus_we = 1'b0; bus_addr = 5'h00; bus_wdata = 8'h00;
    ep0_status = 8'h00; ep1_status = 8'h00; ep2_status = 8'hA5; ep3_status = 8'h00;
    ep0_tt = 2'd0; ep1_tt = 2'd0; ep2_tt = 2'd2; ep3_tt = 2'd0;
    ep0_nak_tt = 2'd0; ep1_nak_tt = 2'd0; ep2_nak_tt = 2'd1; ep3_nak_tt = 2'd0;
    clr_ep0_rdy = 1'b0; clr_ep1_rdy = 1'b0; clr_ep2_rdy = 1'b0; clr_ep3_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ep0_ctrl", {3'b0, ep0_ctrl}, 8'h00);
    chk("rst_ep1_ctrl", {3'b0, ep1_ctrl}, 8'h00);
    chk("rst_ep2_ctrl", {3'b0, ep2_ctrl}, 8'h00);
    chk("rst_ep3_ctrl", {3'b0, ep3_ctrl}, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_ack", {7'b0, bus_ack}, 8'h00);
    access(1'b0, 5'h11, 8'h00, 8'h00);
    access(1'b0, 5'h13, 8'h00, 8'h00);
    access(1'b0, 5'h09, 8'h00, 8'hA5);
    access(1'b0, 5'h0A, 8'h00, 8'h06);
    access(1'b0, 5'h0B, 8'h00, 8'h00);
    access(1'b0, 5'h10, 8'h00, 8'h00);

    // Plain write and readback
    access(1'b1, 5'h08, 8'h03, 8'h00);
    chk("ep2_ctrl_wr", {3'b0, ep2_ctrl}, 8'h03);
    access(1'b0, 5'h08, 8'h00, 8'h03);
    access(1'b1, 5'h13, 8'hFF, 8'h00);
    access(1'b0, 5'h13, 8'h00, 8'h00);

    // READY auto-clear with held clr level
    access(1'b1, 5'h04, 8'h03, 8'h00);
    access(1'b1, 5'h11, 8'h02, 8'h00);
    chk("ep1_ctrl_pre", {3'b0, ep1_ctrl}, 8'h03);
    clr_ep1_rdy = 1'b1;
    @(negedge clk);
    chk("ep1_ready_clr", {3'b0, ep1_ctrl}, 8'h01);
    chk("irq_not_yet", {7'b0, irq}, 8'h00);
    @(negedge clk);
    chk("irq_raised", {7'b0, irq}, 8'h01);
    access(1'b1, 5'h04, 8'h03, 8'h00);
    chk("ep1_rewrite", {3'b0, ep1_ctrl}, 8'h03);
    repeat (5) @(negedge clk);
    chk("ep1_held_clr", {3'b0, ep1_ctrl}, 8'h03);
    access(1'b0, 5'h10, 8'h00, 8'h02);
    clr_ep1_rdy = 1'b0;

    // Host write collides with clr edge: hardware wins on READY
    @(negedge clk);
    clr_ep0_rdy = 1'b1;
    access(1'b1, 5'h00, 8'h1F, 8'h00);
    chk("ep0_collide", {3'b0, ep0_ctrl}, 8'h1D);
    access(1'b0, 5'h00, 8'h00, 8'h1D);
    access(1'b0, 5'h10, 8'h00, 8'h03);
    clr_ep0_rdy = 1'b0;

    // NAK interrupt and W1C races
    access(1'b1, 5'h10, 8'hFF, 8'h00);
    access(1'b1, 5'h11, 8'h80, 8'h00);
    access(1'b0, 5'h10, 8'h00, 8'h00);
    chk("irq_after_w1c_all", {7'b0, irq}, 8'h00);
    ep3_status = 8'h10;
    @(negedge clk);
    access(1'b0, 5'h10, 8'h00, 8'h80);
    chk("irq_nak", {7'b0, irq}, 8'h01);
    ep3_status = 8'h00;
    @(negedge clk);
    ep3_status = 8'h10;
    access(1'b1, 5'h10, 8'h80, 8'h00);
    access(1'b0, 5'h10, 8'h00, 8'h80);
    access(1'b1, 5'h10, 8'h80, 8'h00);
    chk("irq_at_w1c_ack", {7'b0, irq_at_ack}, 8'h01);
    chk("irq_dropped", {7'b0, irq}, 8'h00);
    access(1'b0, 5'h10, 8'h00, 8'h00);

    // Reset during the access cycle of a write
    access(1'b1, 5'h04, 8'h03, 8'h00);
    bus_stb = 1'b1; bus_we = 1'b1; bus_addr = 5'h04; bus_wdata = 8'h1F; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus_stb = 1'b0;
    chk("rst_abort_ack", {7'b0, bus_ack}, 8'h00);
    chk("rst_abort_ep1", {3'b0, ep1_ctrl}, 8'h00);
    @(negedge clk);
    chk("rst_abort_ack2", {7'b0, bus_ack}, 8'h00);
    access(1'b0, 5'h11, 8'h00, 8'h00);

    chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
